// File: rtl/fir_pkg.sv
// ============================================================================
// Module      : fir_pkg
// Description : Shared constants for the parallel FIR output path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;
    localparam int LANES     = 6;
    localparam int BUF_DEPTH = 2;
    localparam int DROP_W    = 8;

    typedef logic [2:0] lane_idx_t;
endpackage

`default_nettype wire

// File: rtl/round_sat.sv
// ============================================================================
// Module      : round_sat
// Description : Round-half-up right shift followed by signed saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module round_sat #(
    parameter int Y_IN  = 20,
    parameter int W_OUT = 16,
    parameter int SHIFT = 4
) (
    input  logic signed [Y_IN-1:0]  din,
    output logic signed [W_OUT-1:0] dout,
    output logic                    sat
);
    localparam logic signed [Y_IN:0] c_half = (Y_IN+1)'(2 ** (SHIFT - 1));
    localparam logic signed [Y_IN:0] c_max  = (Y_IN+1)'((2 ** (W_OUT - 1)) - 1);
    localparam logic signed [Y_IN:0] c_min  = (Y_IN+1)'(-(2 ** (W_OUT - 1)));

    logic signed [Y_IN:0] w_ext;
    logic signed [Y_IN:0] w_sh;

    // One guard bit keeps the rounding add from wrapping at the positive limit.
    assign w_ext = {din[Y_IN-1], din} + c_half;
    assign w_sh  = w_ext >>> SHIFT;

    always_comb begin
        sat  = 1'b0;
        dout = w_sh[W_OUT-1:0];
        if (w_sh > c_max) begin
            sat  = 1'b1;
            dout = c_max[W_OUT-1:0];
        end else if (w_sh < c_min) begin
            sat  = 1'b1;
            dout = c_min[W_OUT-1:0];
        end
    end
endmodule

`default_nettype wire

// File: rtl/ser_gen.sv
// ============================================================================
// Module      : ser_gen
// Description : Six-lane block to serial stream converter with 2-block buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_gen
    import fir_pkg::*;
#(
    parameter int Y_IN  = 20,
    parameter int W_OUT = 16,
    parameter int SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [Y_IN-1:0]  y0,
    input  logic signed [Y_IN-1:0]  y1,
    input  logic signed [Y_IN-1:0]  y2,
    input  logic signed [Y_IN-1:0]  y3,
    input  logic signed [Y_IN-1:0]  y4,
    input  logic signed [Y_IN-1:0]  y5,
    output logic signed [W_OUT-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    blk_drop,
    output logic [DROP_W-1:0]       drop_cnt,
    output logic                    sat_flag
);
    logic signed [Y_IN-1:0]  w_lane_in  [LANES];
    logic signed [W_OUT-1:0] w_lane_rs  [LANES];
    logic [LANES-1:0]        w_lane_sat;

    logic signed [W_OUT-1:0] r_buf [BUF_DEPTH][LANES];
    logic [1:0]              r_count;
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    lane_idx_t               r_lane;
    logic                    r_blk_drop;
    logic [DROP_W-1:0]       r_drop_cnt;
    logic                    r_sat_flag;

    logic w_valid;
    logic w_xfer;
    logic w_last;
    logic w_full;
    logic w_accept;
    logic w_drop;

    assign w_lane_in[0] = y0;
    assign w_lane_in[1] = y1;
    assign w_lane_in[2] = y2;
    assign w_lane_in[3] = y3;
    assign w_lane_in[4] = y4;
    assign w_lane_in[5] = y5;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            round_sat #(
                .Y_IN  (Y_IN),
                .W_OUT (W_OUT),
                .SHIFT (SHIFT)
            ) u_round_sat (
                .din  (w_lane_in[gi]),
                .dout (w_lane_rs[gi]),
                .sat  (w_lane_sat[gi])
            );
        end
    endgenerate

    // Acceptance looks at the pre-edge count: a full buffer drops even if a
    // block completes in the same cycle.
    assign w_valid  = (r_count != 2'd0);
    assign w_xfer   = w_valid && dout_ready;
    assign w_last   = w_xfer && (r_lane == lane_idx_t'(LANES - 1));
    assign w_full   = (r_count == 2'(BUF_DEPTH));
    assign w_accept = in_valid && !w_full;
    assign w_drop   = in_valid && w_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < BUF_DEPTH; b++) begin
                for (int l = 0; l < LANES; l++) begin
                    r_buf[b][l] <= '0;
                end
            end
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_lane     <= '0;
            r_blk_drop <= 1'b0;
            r_drop_cnt <= '0;
            r_sat_flag <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int l = 0; l < LANES; l++) begin
                    r_buf[r_wr_ptr][l] <= w_lane_rs[l];
                end
                r_wr_ptr <= ~r_wr_ptr;
                if (|w_lane_sat) begin
                    r_sat_flag <= 1'b1;
                end
            end

            if (w_xfer) begin
                if (w_last) begin
                    r_lane   <= '0;
                    r_rd_ptr <= ~r_rd_ptr;
                end else begin
                    r_lane <= r_lane + lane_idx_t'(1);
                end
            end

            case ({w_accept, w_last})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            r_blk_drop <= w_drop;
            if (w_drop && (r_drop_cnt != {DROP_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    assign dout       = r_buf[r_rd_ptr][r_lane];
    assign dout_valid = w_valid;
    assign blk_drop   = r_blk_drop;
    assign drop_cnt   = r_drop_cnt;
    assign sat_flag   = r_sat_flag;
endmodule

`default_nettype wire

// File: tb/tb_ser_gen.sv
// ============================================================================
// Module      : tb_ser_gen
// Description : Self-checking bench for ser_gen against a sample-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ser_gen;
    localparam int Y_IN  = 20;
    localparam int W_OUT = 16;
    localparam int SHIFT = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic signed [Y_IN-1:0]  y [6];
    logic signed [W_OUT-1:0] dout;
    logic                    dout_valid;
    logic                    dout_ready = 1'b0;
    logic                    blk_drop;
    logic [7:0]              drop_cnt;
    logic                    sat_flag;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model: flat FIFO of rounded samples, block count derived from it.
    int m_q[$];
    bit m_drop = 1'b0;
    int m_cnt  = 0;
    bit m_sat  = 1'b0;

    always #5 clk = ~clk;

    ser_gen #(.Y_IN(Y_IN), .W_OUT(W_OUT), .SHIFT(SHIFT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .y0         (y[0]),
        .y1         (y[1]),
        .y2         (y[2]),
        .y3         (y[3]),
        .y4         (y[4]),
        .y5         (y[5]),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .blk_drop   (blk_drop),
        .drop_cnt   (drop_cnt),
        .sat_flag   (sat_flag)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int round_ref(input int v, output bit s);
        int r;
        int hi;
        int lo;
        hi = (1 << (W_OUT - 1)) - 1;
        lo = -(1 << (W_OUT - 1));
        r  = (v + (1 << (SHIFT - 1))) >>> SHIFT;
        s  = 1'b0;
        if (r > hi) begin r = hi; s = 1'b1; end
        if (r < lo) begin r = lo; s = 1'b1; end
        return r;
    endfunction

    always @(posedge clk) begin
        int  nblk;
        bit  s;
        int  r;
        if (rst) begin
            m_q.delete();
            m_drop = 1'b0;
            m_cnt  = 0;
            m_sat  = 1'b0;
        end else begin
            nblk   = (m_q.size() + 5) / 6;
            m_drop = in_valid && (nblk == 2);
            if (m_drop && m_cnt < 255) m_cnt++;
            if (m_q.size() > 0 && dout_ready) void'(m_q.pop_front());
            if (in_valid && nblk < 2) begin
                for (int i = 0; i < 6; i++) begin
                    r = round_ref(int'(y[i]), s);
                    m_q.push_back(r);
                    if (s) m_sat = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", int'(dout_valid), int'(m_q.size() != 0));
            if (m_q.size() != 0) chk("model_dout", int'(dout), m_q[0]);
            chk("model_blk_drop", int'(blk_drop), int'(m_drop));
            chk("model_drop_cnt", int'(drop_cnt), m_cnt);
            chk("model_sat_flag", int'(sat_flag), int'(m_sat));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int v0, input int v1, input int v2,
                         input int v3, input int v4, input int v5);
        y[0] = Y_IN'(v0); y[1] = Y_IN'(v1); y[2] = Y_IN'(v2);
        y[3] = Y_IN'(v3); y[4] = Y_IN'(v4); y[5] = Y_IN'(v5);
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    int exp_basic [6] = '{6, -6, 1, 0, 0, -1};

    initial begin
        for (int i = 0; i < 6; i++) y[i] = '0;
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", int'(dout_valid), 0);
        chk("reset_dout", int'(dout), 0);
        chk("reset_drop_cnt", int'(drop_cnt), 0);
        chk("reset_sat", int'(sat_flag), 0);
        chk_en = 1'b1;
        tick(1);

        // Basic stream with literal expectations.
        dout_ready = 1'b1;
        pulse(100, -100, 8, 7, -8, -9);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("basic_valid", int'(dout_valid), 1);
            chk("basic_dout", int'(dout), exp_basic[i]);
            tick(1);
        end
        @(negedge clk);
        chk("basic_valid_drop", int'(dout_valid), 0);
        tick(2);

        // Saturation.
        pulse(524287, -524288, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat_pos", int'(dout), 32767);
        chk("sat_flag_set", int'(sat_flag), 1);
        tick(1);
        @(negedge clk);
        chk("sat_neg", int'(dout), -32768);
        tick(10);
        chk("sat_flag_sticky", int'(sat_flag), 1);

        // Backpressure.
        dout_ready = 1'b0;
        pulse(160, 320, 480, 640, 800, 960);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(dout_valid), 1);
            chk("bp_hold_dout", int'(dout), 10);
            tick(1);
        end
        dout_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_stream", int'(dout), 10 * (i + 1));
            tick(1);
        end
        tick(2);

        // Full buffer: third block dropped.
        dout_ready = 1'b0;
        pulse(16, 32, 48, 64, 80, 96);
        tick(5);
        pulse(-16, -32, -48, -64, -80, -96);
        tick(5);
        pulse(1600, 1600, 1600, 1600, 1600, 1600);
        @(negedge clk);
        chk("full_blk_drop", int'(blk_drop), 1);
        chk("full_drop_cnt", int'(drop_cnt), 1);
        tick(1);
        @(negedge clk);
        chk("full_blk_drop_clear", int'(blk_drop), 0);
        tick(1);
        dout_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("full_order", int'(dout), (i < 6) ? (i + 1) : -(i - 5));
            tick(1);
        end
        @(negedge clk);
        chk("full_empty", int'(dout_valid), 0);

        // Back-to-back blocks: no gaps once streaming.
        do_reset();
        for (int b = 0; b < 10; b++) begin
            y[0] = Y_IN'(b * 96);       y[1] = Y_IN'(b * 96 + 16);
            y[2] = Y_IN'(b * 96 + 32);  y[3] = Y_IN'(b * 96 + 48);
            y[4] = Y_IN'(b * 96 + 64);  y[5] = Y_IN'(b * 96 + 80);
            in_valid = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (b != 0 || c != 0) begin
                    chk("b2b_valid", int'(dout_valid), 1);
                    chk("b2b_dout", int'(dout), b * 6 + c - 1);
                end
                tick(1);
                in_valid = 1'b0;
            end
        end
        tick(8);
        chk("b2b_drop_cnt", int'(drop_cnt), 0);

        // Reset mid-block.
        pulse(16, 32, 48, 64, 80, 96);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", int'(dout_valid), 0);
        chk("rst_mid_drop_cnt", int'(drop_cnt), 0);
        chk("rst_mid_sat", int'(sat_flag), 0);
        tick(1);
        pulse(48, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_restart_lane0", int'(dout), 3);
        tick(8);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            in_valid   = ($urandom_range(0, 4) == 0);
            dout_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 6; i++) begin
                case ($urandom_range(0, 7))
                    0:       y[i] = Y_IN'(524287 - $urandom_range(0, 9));
                    1:       y[i] = Y_IN'(-524288 + $urandom_range(0, 9));
                    default: y[i] = Y_IN'($urandom);
                endcase
            end
            tick(1);
        end
        in_valid   = 1'b0;
        dout_ready = 1'b1;
        tick(20);
        @(negedge clk);
        chk("final_drained", int'(dout_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
